// File: rtl/imm_enc_pkg.sv
// Shared opcodes, classes and FSM states for the constant-load encoder.
// Optional word counter is enabled by IMM_ENC_CNT_EN (see imm_enc).
package imm_enc_pkg;

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {SEXT, ZEXT, HIGH, FULL} imm_cls_e;
  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_e;

  // Pending second-word data for a FULL sequence
  typedef struct packed {
    logic [4:0]  rt;
    logic [15:0] lo;
  } imm_pend_t;

  function automatic logic [31:0] mk_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imm_fit_classify.sv
// Decides which single I-type instruction (if any) can materialise a 32-bit constant.
module imm_fit_classify
  import imm_enc_pkg::*;
(
  input  logic [31:0] value,
  output imm_cls_e    cls
);

  // Priority order matters: 0 must resolve to addiu, 0x8000 to ori
  always_comb begin
    cls = FULL;
    if (value[31:16] == {16{value[15]}}) cls = SEXT;
    else if (value[31:16] == 16'h0)      cls = ZEXT;
    else if (value[15:0] == 16'h0)       cls = HIGH;
  end

endmodule

// File: rtl/imm_enc.sv
// Constant-load encoder: emits addiu / ori / lui / lui+ori for a 32-bit value.
// Define IMM_ENC_CNT_EN to add the word_cnt output (accepted output words, wraps).
module imm_enc
  import imm_enc_pkg::*;
#(
  parameter logic [4:0] BASE_REG = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef IMM_ENC_CNT_EN
  output logic [15:0] word_cnt,
`endif
  output logic        out_last
);

  state_e    state_q, state_d;
  imm_cls_e  cls;
  imm_pend_t pend_q;
  logic [31:0] first_word;
  logic        xfer;

  imm_fit_classify u_cls (
    .value (in_value),
    .cls   (cls)
  );

  always_comb begin
    case (cls)
      SEXT:    first_word = mk_word(OP_ADDIU, BASE_REG, in_rt, in_value[15:0]);
      ZEXT:    first_word = mk_word(OP_ORI,   BASE_REG, in_rt, in_value[15:0]);
      default: first_word = mk_word(OP_LUI,   5'd0,     in_rt, in_value[31:16]);
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = EMIT1;
      EMIT1:   if (out_ready) state_d = out_last ? IDLE : EMIT2;
      EMIT2:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output word/last are registered so they hold steady through any stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_instr <= '0;
      out_last  <= 1'b0;
      pend_q    <= '0;
    end else if (state_q == IDLE && in_valid) begin
      out_instr <= first_word;
      out_last  <= (cls != FULL);
      pend_q    <= '{rt: in_rt, lo: in_value[15:0]};
    end else if (state_q == EMIT1 && out_ready && !out_last) begin
      out_instr <= mk_word(OP_ORI, pend_q.rt, pend_q.rt, pend_q.lo);
      out_last  <= 1'b1;
    end else if (xfer && out_last) begin
      out_instr <= '0;
      out_last  <= 1'b0;
    end
  end

`ifdef IMM_ENC_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    word_cnt <= '0;
    else if (xfer) word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_imm_enc.sv
// Self-checking bench for imm_enc: directed plan vectors, stalls, mid-sequence reset, random traffic.
module tb_imm_enc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_value = '0;
  logic [4:0]  in_rt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_last;
`ifdef IMM_ENC_CNT_EN
  logic [15:0] word_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  imm_enc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_rt     (in_rt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
`ifdef IMM_ENC_CNT_EN
    .word_cnt  (word_cnt),
`endif
    .out_last  (out_last)
  );

  // Reference: pick the shortest sequence from the numeric range of the constant
  function automatic int model(input logic [31:0] v, input logic [4:0] rt,
                               output logic [31:0] w0, output logic [31:0] w1);
    longint sv;
    logic [31:0] r, lo, hi;
    sv = longint'($signed(v));
    r  = 32'(rt);
    lo = v % 32'd65536;
    hi = v / 32'd65536;
    w1 = '0;
    if (sv >= -32768 && sv <= 32767) begin
      w0 = 32'd9 * 32'h0400_0000 + r * 32'h1_0000 + lo;
      return 1;
    end else if (v < 32'h1_0000) begin
      w0 = 32'd13 * 32'h0400_0000 + r * 32'h1_0000 + lo;
      return 1;
    end else if (lo == 0) begin
      w0 = 32'd15 * 32'h0400_0000 + r * 32'h1_0000 + hi;
      return 1;
    end
    w0 = 32'd15 * 32'h0400_0000 + r * 32'h1_0000 + hi;
    w1 = 32'd13 * 32'h0400_0000 + r * 32'h20_0000 + r * 32'h1_0000 + lo;
    return 2;
  endfunction

  // stall < 0: random 0..3 idle cycles per word; otherwise fixed
  task automatic do_req(input logic [31:0] v, input logic [4:0] rt, input int stall);
    logic [31:0] w [2];
    int nw, k, guard;
    nw = model(v, rt, w[0], w[1]);
    @(negedge clk);
    in_valid = 1'b1; in_value = v; in_rt = rt;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < nw; i++) begin
      k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < k; s++) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_instr !== w[i] || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold v=%h word%0d valid=%b instr=%h in_ready=%b required 1/%h/0",
                   v, i, out_valid, out_instr, in_ready, w[i]);
        end
        @(negedge clk);
      end
      out_ready = 1'b1;
      n_chk++;
      if (out_valid !== 1'b1 || out_instr !== w[i] || out_last !== (i == nw - 1)) begin
        n_fail++;
        $display("FAIL word v=%h rt=%0d word%0d valid=%b instr=%h last=%b required 1/%h/%b",
                 v, rt, i, out_valid, out_instr, out_last, w[i], (i == nw - 1));
      end
      exp_cnt++;
      @(negedge clk);
      out_ready = 1'b0;
    end
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_end v=%h in_ready=%b out_valid=%b required 1/0", v, in_ready, out_valid);
    end
`ifdef IMM_ENC_CNT_EN
    n_chk++;
    if (word_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL word_cnt got %0d required %0d", word_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state rdy=%b vld=%b instr=%h last=%b required 1/0/0/0",
               in_ready, out_valid, out_instr, out_last);
    end
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_directed();
    logic [31:0] w0, w1;
    int nw;
    // Independent check of the model against hand-encoded plan values
    nw = model(32'h1234_5678, 5'd11, w0, w1);
    n_chk++;
    if (nw != 2 || w0 !== 32'h3C0B_1234 || w1 !== 32'h356B_5678) begin
      n_fail++;
      $display("FAIL model_full got %0d %h %h required 2 3c0b1234 356b5678", nw, w0, w1);
    end
    do_req(32'hFFFF_8000, 5'd8, 0);
    do_req(32'h0000_ABCD, 5'd9, 0);
    do_req(32'h1234_0000, 5'd10, 0);
    do_req(32'h1234_5678, 5'd11, 0);
`ifdef IMM_ENC_CNT_EN
    n_chk++;
    if (word_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL cnt_plan got %0d required 5", word_cnt);
    end
`endif
  endtask

  task automatic test_boundaries();
    do_req(32'h0000_0000, 5'd3, 0);
    do_req(32'h0000_8000, 5'd4, 0);
    do_req(32'hFFFF_0000, 5'd5, 1);
    do_req(32'h8000_0000, 5'd6, 0);
    do_req(32'h0001_0001, 5'd0, 0);
    do_req(32'h0000_7FFF, 5'd31, 2);
  endtask

  task automatic test_stall();
    do_req(32'h1234_5678, 5'd11, 5);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_value = 32'hDEAD_BEEF; in_rt = 5'd7;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || out_instr !== 32'h34E7_BEEF) begin
      n_fail++;
      $display("FAIL emit2_entry vld=%b instr=%h required 1/34e7beef", out_valid, out_instr);
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid vld=%b rdy=%b instr=%h last=%b required 0/1/0/0",
               out_valid, in_ready, out_instr, out_last);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 0;
    do_req(32'h0000_0000, 5'd0, 0);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: v = $urandom;
        1: v = 32'($signed(16'($urandom)));
        2: v = $urandom_range(0, 32'hFFFF);
        3: v = {16'($urandom), 16'h0};
        default: v = {16'($urandom_range(1, 3)), 16'($urandom)};
      endcase
      do_req(v, 5'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
